regs_hex_dumper: RTL

//  Downstream consumer of the register file's regs_for_vga bundle (pcpu::rv32_regs_t).
//  On a start pulse it snapshots all 32 GPRs and streams them as ASCII text characters
//  (row, col, char) over a valid/ready port into the VGA text buffer writer.

---
 rtl/regs_hex_dumper.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/regs_hex_dumper.sv
// Register-file hex dumper: snapshots the 32 GPRs on start and streams them as
// "xNN:hhhhhhhh " text entries (row, col, char) over a valid/ready port.

package pcpu;
   // GPR bundle x1..x31; x0 is architecturally zero and not carried.
   typedef struct packed {
      logic [31:1][31:0] x;
   } rv32_regs_t;
endpackage

module regs_hex_dumper #(
   parameter int unsigned REGS_PER_LINE = 4,
   parameter int unsigned ROW_BASE      = 0,
   parameter int unsigned COL_BASE      = 0,
   parameter int unsigned ROW_W         = 5,
   parameter int unsigned COL_W         = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  pcpu::rv32_regs_t   regs,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               char_valid,
   input  logic               char_ready,
   output logic [7:0]         char_data,
   output logic [ROW_W-1:0]   char_row,
   output logic [COL_W-1:0]   char_col
);

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned ENTRY_W  = 13;
   localparam int unsigned IDX_W    = 5;
   localparam int unsigned K_W      = 4;
   localparam int unsigned DATA_W   = 32;

   localparam logic [K_W-1:0]   K_LAST   = K_W'(ENTRY_W - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EMIT,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [K_W-1:0]          k_q, k_d;
   logic [31:1][DATA_W-1:0] snap_q, snap_d;

   logic                    busy_d, done_d, valid_d;
   logic [7:0]              data_d;
   logic [ROW_W-1:0]        row_d;
   logic [COL_W-1:0]        col_d;

   // Snapshot word for an entry index; x0 reads as zero.
   function automatic logic [DATA_W-1:0] sel_word(input logic [IDX_W-1:0]        i,
                                                  input logic [31:1][DATA_W-1:0] s);
      logic [DATA_W-1:0] w;
      w = '0;
      for (int r = 1; r < int'(NUM_REGS); r++) begin
         if (i == IDX_W'(r)) w = s[r];
      end
      return w;
   endfunction

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

   // Character k of the text entry for register idx holding word w.
   function automatic logic [7:0] entry_char(input logic [IDX_W-1:0]  idx,
                                             input logic [K_W-1:0]    k,
                                             input logic [DATA_W-1:0] w);
      logic [4:0] sh;
      logic [7:0] c;
      sh = 5'(4'd11 - k) << 2;
      case (k)
         4'd0:    c = 8'h78;
         4'd1:    c = 8'h30 + 8'(idx / 5'd10);
         4'd2:    c = 8'h30 + 8'(idx % 5'd10);
         4'd3:    c = 8'h3A;
         4'd12:   c = 8'h20;
         default: c = hex_ascii(4'(w >> sh));
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      k_d     = k_q;
      snap_d  = snap_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               snap_d  = regs.x;
               idx_d   = '0;
               k_d     = '0;
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            if (char_valid && char_ready) begin
               if (k_q < K_LAST) begin
                  k_d = k_q + K_W'(1);
               end else begin
                  k_d   = '0;
                  idx_d = idx_q + IDX_W'(1);
                  if (idx_q == IDX_LAST) state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from next-state values so they align with state_q.
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
      valid_d = (state_d == S_EMIT);
      data_d  = '0;
      row_d   = '0;
      col_d   = '0;
      if (state_d == S_EMIT) begin
         data_d = entry_char(idx_d, k_d, sel_word(idx_d, snap_d));
         row_d  = ROW_W'(ROW_BASE + 32'(idx_d) / REGS_PER_LINE);
         col_d  = COL_W'(COL_BASE + (32'(idx_d) % REGS_PER_LINE) * ENTRY_W + 32'(k_d));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         k_q        <= '0;
         snap_q     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         char_valid <= 1'b0;
         char_data  <= '0;
         char_row   <= '0;
         char_col   <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         k_q        <= k_d;
         snap_q     <= snap_d;
         busy       <= busy_d;
         done       <= done_d;
         char_valid <= valid_d;
         char_data  <= data_d;
         char_row   <= row_d;
         char_col   <= col_d;
      end
   end

endmodule
